// File: rtl/tpu_pkg.sv
// Shared definitions for the tpumac systolic array, its skew feeder and the
// C-drain block.
//   TPU_BITS_AB : default operand width
//   TPU_DIM     : default array dimension (number of lanes)
//   feeder_state_t : skew feeder control state
package tpu_pkg;

    localparam int unsigned TPU_BITS_AB = 8;
    localparam int unsigned TPU_DIM     = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/tpu_skew_feeder_lane.sv
// skew_lane: one delay chain of DEPTH stages carrying a valid bit and data.
//   clk, rst_n : clock, async active-low reset
//   en         : advance enable; en=0 freezes every stage
//   clr        : synchronous flush of every stage
//   in_valid   : stage 0 loads in_data when set, otherwise a zero bubble
//   in_data    : lane operand
//   out_valid  : last-stage valid
//   out_data   : last-stage data (0 whenever out_valid is 0)
//   any_valid  : some stage of the chain holds real data
module skew_lane #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             any_valid
);

    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat [DEPTH];

    // Shift chain; bubbles carry zero data so downstream MACs add nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < int'(DEPTH); i++) dat[i] <= '0;
        end else if (clr) begin
            vld <= '0;
            for (int i = 0; i < int'(DEPTH); i++) dat[i] <= '0;
        end else if (en) begin
            vld[0] <= in_valid;
            dat[0] <= in_valid ? in_data : '0;
            for (int i = 1; i < int'(DEPTH); i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];
    assign any_valid = |vld;

endmodule

// File: rtl/tpu_skew_feeder.sv
// tpu_skew_feeder: skews one DIM-wide row of A operands per cycle onto the
// systolic array's left edge, lane i delayed by i+1 enabled cycles.
//   clk, rst_n : clock, async active-low reset
//   en         : global advance enable (shared with the array)
//   clr        : sync clear: flush lanes, return to IDLE
//   in_valid   : in_vec holds a row; in_last marks the final row of a matrix
//   in_vec     : row, lane i = in_vec[i*BITS_AB +: BITS_AB]
//   in_ready   : row can be accepted this cycle (combinational on state, en)
//   out_vec    : skewed operands to the array Ain column
//   out_valid  : per-lane real-data flag
//   busy       : any lane holds data or the FSM is not IDLE
//   done       : last row's lane DIM-1 operand is visible this cycle
module tpu_skew_feeder
    import tpu_pkg::*;
#(
    parameter int unsigned BITS_AB = TPU_BITS_AB,
    parameter int unsigned DIM     = TPU_DIM
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   clr,
    input  logic                   in_valid,
    input  logic                   in_last,
    input  logic [DIM*BITS_AB-1:0] in_vec,
    output logic                   in_ready,
    output logic [DIM*BITS_AB-1:0] out_vec,
    output logic [DIM-1:0]         out_valid,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned CNT_W = $clog2(DIM) + 1;

    feeder_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic [DIM-1:0]   lane_busy;

    assign in_ready = en & (state != DRAIN);
    assign accept   = in_valid & in_ready;

    // One delay chain per lane, depth i+1, forming the diagonal wavefront.
    for (genvar i = 0; i < int'(DIM); i++) begin : g_lane
        skew_lane #(
            .WIDTH (BITS_AB),
            .DEPTH (i + 1)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .clr       (clr),
            .in_valid  (accept),
            .in_data   (in_vec[i*BITS_AB +: BITS_AB]),
            .out_valid (out_valid[i]),
            .out_data  (out_vec[i*BITS_AB +: BITS_AB]),
            .any_valid (lane_busy[i])
        );
    end

    // Control FSM; cnt counts the enabled edges until the last row's
    // lane DIM-1 operand leaves its chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (clr) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_last) begin
                            state <= DRAIN;
                            cnt   <= CNT_W'(DIM - 1);
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (accept && in_last) begin
                        state <= DRAIN;
                        cnt   <= CNT_W'(DIM - 1);
                    end
                end
                DRAIN: begin
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                    else           state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign done = (state == DRAIN) && (cnt == '0);
    assign busy = (|lane_busy) | (state != IDLE);

endmodule
